// File: rtl/lsu_ctrl_if.sv
// Bus-side request/response channel between the load/store controller and memory.
interface lsu_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [7:0]  req_wstrb;
  logic        resp_valid;
  logic [63:0] resp_data;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_wstrb,
    input  req_ready, resp_valid, resp_data
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_wstrb,
    output req_ready, resp_valid, resp_data
  );
endinterface

// File: rtl/lsu_ctrl.sv
// Load/store controller: one outstanding doubleword bus access with lane alignment and extension.
// Define MISALIGN_TRAP_EN to trap misaligned accesses straight to DONE without touching the bus.
module lsu_ctrl (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic        mem_r_i,
  input  logic        mem_w_i,
  input  logic [2:0]  funct3_i,
  input  logic [63:0] addr_i,
  input  logic [63:0] wdata_i,
  output logic        stall_o,
  output logic        done_o,
  output logic [63:0] rdata_o,
  output logic        misalign_o,
  lsu_ctrl_if.master  bus
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

  state_e      state_q, state_d;
  logic [2:0]  funct3_q;
  logic [63:0] addr_q;
  logic [63:0] wdata_q;
  logic        we_q;
  logic [63:0] rdata_q;

  logic        accept;
  logic        trapNow;
  logic [63:0] loadShifted;
  logic [63:0] loadExt;
  logic [7:0]  sizeMask;
  logic [7:0]  storeStrb;
  logic [63:0] storeData;

  // Both mem_r and mem_w set falls through as a store because direction is taken from mem_w alone.
  assign accept = start_i & (mem_r_i | mem_w_i);

`ifdef MISALIGN_TRAP_EN
  logic accessMis;
  logic misalign_q;

  always_comb begin
    case (funct3_i[1:0])
      2'b00:   accessMis = 1'b0;
      2'b01:   accessMis = addr_i[0];
      2'b10:   accessMis = |addr_i[1:0];
      default: accessMis = |addr_i[2:0];
    endcase
  end

  assign trapNow = accessMis;

  always_ff @(posedge clk_i) begin
    if (!rst_ni)
      misalign_q <= 1'b0;
    else if (state_q == IDLE && accept)
      misalign_q <= trapNow;
  end

  assign misalign_o = (state_q == DONE) & misalign_q;
`else
  assign trapNow    = 1'b0;
  assign misalign_o = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_ni)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = trapNow ? DONE : REQ;
      REQ:     if (bus.req_ready) state_d = WAIT;
      WAIT:    if (bus.resp_valid) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      funct3_q <= 3'b000;
      addr_q   <= 64'd0;
      wdata_q  <= 64'd0;
      we_q     <= 1'b0;
      rdata_q  <= 64'd0;
    end else begin
      if (state_q == IDLE && accept) begin
        funct3_q <= funct3_i;
        addr_q   <= addr_i;
        wdata_q  <= wdata_i;
        we_q     <= mem_w_i;
      end
      if (state_q == WAIT && bus.resp_valid && !we_q)
        rdata_q <= loadExt;
    end
  end

  // Bytes that fall past the doubleword boundary shift out and are lost, both for loads and stores.
  assign loadShifted = bus.resp_data >> {addr_q[2:0], 3'b000};

  always_comb begin
    case (funct3_q)
      3'b000:  loadExt = {{56{loadShifted[7]}},  loadShifted[7:0]};
      3'b001:  loadExt = {{48{loadShifted[15]}}, loadShifted[15:0]};
      3'b010:  loadExt = {{32{loadShifted[31]}}, loadShifted[31:0]};
      3'b100:  loadExt = {56'd0, loadShifted[7:0]};
      3'b101:  loadExt = {48'd0, loadShifted[15:0]};
      3'b110:  loadExt = {32'd0, loadShifted[31:0]};
      default: loadExt = loadShifted;
    endcase
  end

  always_comb begin
    case (funct3_q[1:0])
      2'b00:   sizeMask = 8'h01;
      2'b01:   sizeMask = 8'h03;
      2'b10:   sizeMask = 8'h0F;
      default: sizeMask = 8'hFF;
    endcase
  end

  assign storeStrb = sizeMask << addr_q[2:0];
  assign storeData = wdata_q << {addr_q[2:0], 3'b000};
  assign rdata_o   = rdata_q;

  always_comb begin
    stall_o       = 1'b0;
    done_o        = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = 64'd0;
    bus.req_wdata = 64'd0;
    bus.req_wstrb = 8'h00;
    case (state_q)
      IDLE: stall_o = accept & rst_ni;
      REQ: begin
        stall_o       = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_we    = we_q;
        bus.req_addr  = {addr_q[63:3], 3'b000};
        if (we_q) begin
          bus.req_wdata = storeData;
          bus.req_wstrb = storeStrb;
        end
      end
      WAIT:    stall_o = 1'b1;
      DONE:    done_o  = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: scoreboard of expected load results plus cycle-accurate handshake checks.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, memR, memW;
  logic [2:0]  funct3;
  logic [63:0] addr, wdata;
  logic        stall, done, misalign;
  logic [63:0] rdata;

  lsu_ctrl_if bus ();

  lsu_ctrl dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .start_i    (start),
    .mem_r_i    (memR),
    .mem_w_i    (memW),
    .funct3_i   (funct3),
    .addr_i     (addr),
    .wdata_i    (wdata),
    .stall_o    (stall),
    .done_o     (done),
    .rdata_o    (rdata),
    .misalign_o (misalign),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] rdata;
    logic        mis;
    bit          chkData;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon;
  int          checks   = 0;
  int          failures = 0;
  logic [63:0] lastRdata = 64'd0;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=0x%h expected=0x%h", tag, observed, expected);
    end
  endtask

  function automatic int sizeBytes(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit misModel(input logic [2:0] f3, input logic [63:0] a);
    int n = sizeBytes(f3);
    return (int'(a[2:0]) % n) != 0;
  endfunction

  function automatic logic [63:0] loadModel(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] resp);
    logic [63:0] v;
    int n    = sizeBytes(f3);
    int base = int'(a[2:0]);
    v = 64'd0;
    for (int i = 0; i < n; i++)
      if (base + i < 8) v[8*i +: 8] = resp[8*(base+i) +: 8];
    if (!f3[2] && n < 8)
      for (int j = 8*n; j < 64; j++) v[j] = v[8*n-1];
    return v;
  endfunction

  function automatic logic [7:0] strbModel(input logic [2:0] f3, input logic [63:0] a);
    logic [7:0] s;
    int n    = sizeBytes(f3);
    int base = int'(a[2:0]);
    s = 8'h00;
    for (int i = 0; i < n; i++)
      if (base + i < 8) s[base+i] = 1'b1;
    return s;
  endfunction

  function automatic logic [63:0] wdataModel(input logic [63:0] a, input logic [63:0] wd);
    logic [63:0] w;
    int base = int'(a[2:0]);
    w = 64'd0;
    for (int i = 0; base + i < 8; i++) w[8*(base+i) +: 8] = wd[8*i +: 8];
    return w;
  endfunction

  // Every done pulse retires the oldest scoreboard entry.
  always @(negedge clk) begin
    #2;
    if (done === 1'b1) begin
      if (sb.size() == 0)
        checkOutput("sb_unexpected_done", {63'd0, done}, 64'd0);
      else begin
        mon = sb.pop_front();
        checkOutput("sb_misalign", {63'd0, misalign}, {63'd0, mon.mis});
        if (mon.chkData) checkOutput("sb_rdata", rdata, mon.rdata);
      end
    end
  end

  task automatic applyStimulus(input logic rd, input logic wr, input logic [2:0] f3,
                               input logic [63:0] a, input logic [63:0] wd, input logic [63:0] resp,
                               input int readyDelay, input int respDelay, input bit ghostStart);
    exp_t        e;
    bit          trap;
    bit          st = wr;
    logic [63:0] expAddr = a & ~64'h7;
`ifdef MISALIGN_TRAP_EN
    trap = misModel(f3, a);
`else
    trap = 1'b0;
`endif
    e.mis     = trap;
    e.chkData = !st || trap;
    e.rdata   = (trap || st) ? lastRdata : loadModel(f3, a, resp);
    lastRdata = e.rdata;
    sb.push_back(e);

    @(negedge clk);
    start = 1'b1; memR = rd; memW = wr; funct3 = f3; addr = a; wdata = wd;
    #1 checkOutput("stall_c0", {63'd0, stall}, 64'd1);

    @(negedge clk);
    start = 1'b0; memR = 1'b0; memW = 1'b0; funct3 = 3'($urandom); addr = {$urandom, $urandom}; wdata = {$urandom, $urandom};
    #1;
    if (trap) begin
      checkOutput("trap_done", {63'd0, done}, 64'd1);
      checkOutput("trap_noreq", {63'd0, bus.req_valid}, 64'd0);
      checkOutput("trap_stall", {63'd0, stall}, 64'd0);
      return;
    end

    for (int c = 0; c <= readyDelay; c++) begin
      if (c > 0) @(negedge clk);
      if (ghostStart && c == 1) begin
        start = 1'b1; memR = 1'b1; memW = 1'b0; funct3 = 3'b011; addr = a + 64'h100;
      end else begin
        start = 1'b0;
      end
      bus.req_ready = (c == readyDelay);
      #1;
      checkOutput("req_valid", {63'd0, bus.req_valid}, 64'd1);
      checkOutput("req_we", {63'd0, bus.req_we}, {63'd0, st});
      checkOutput("req_addr", bus.req_addr, expAddr);
      checkOutput("req_stall", {63'd0, stall}, 64'd1);
      if (st) begin
        checkOutput("req_wstrb", {56'd0, bus.req_wstrb}, {56'd0, strbModel(f3, a)});
        checkOutput("req_wdata", bus.req_wdata, wdataModel(a, wd));
      end
    end

    @(negedge clk);
    bus.req_ready = 1'b0; start = 1'b0; memR = 1'b0;
    for (int c = 0; c <= respDelay; c++) begin
      if (c > 0) @(negedge clk);
      bus.resp_valid = (c == respDelay);
      bus.resp_data  = (c == respDelay) ? resp : {$urandom, $urandom};
      #1;
      checkOutput("wait_noreq", {63'd0, bus.req_valid}, 64'd0);
      checkOutput("wait_stall", {63'd0, stall}, 64'd1);
      checkOutput("wait_nodone", {63'd0, done}, 64'd0);
    end

    @(negedge clk);
    bus.resp_valid = 1'b0; bus.resp_data = {$urandom, $urandom};
    #1;
    checkOutput("done_pulse", {63'd0, done}, 64'd1);
    checkOutput("done_stall", {63'd0, stall}, 64'd0);

    @(negedge clk);
    #1;
    checkOutput("done_once", {63'd0, done}, 64'd0);
    checkOutput("idle_stall", {63'd0, stall}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic        rnd;
    logic [2:0]  f3;
    logic [63:0] a;

    rst_n = 1'b0; start = 1'b0; memR = 1'b0; memW = 1'b0;
    funct3 = 3'b000; addr = 64'd0; wdata = 64'd0;
    bus.req_ready = 1'b0; bus.resp_valid = 1'b0; bus.resp_data = 64'd0;

    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_stall", {63'd0, stall}, 64'd0);
    checkOutput("rst_done", {63'd0, done}, 64'd0);
    checkOutput("rst_rdata", rdata, 64'd0);
    checkOutput("rst_misalign", {63'd0, misalign}, 64'd0);
    checkOutput("rst_req_valid", {63'd0, bus.req_valid}, 64'd0);
    checkOutput("rst_req_addr", bus.req_addr, 64'd0);
    checkOutput("rst_req_wstrb", {56'd0, bus.req_wstrb}, 64'd0);
    rst_n = 1'b1;

    applyStimulus(1, 0, 3'b011, 64'h1000, 64'd0, 64'h1122334455667788, 0, 0, 0);
    applyStimulus(1, 0, 3'b000, 64'h1003, 64'd0, 64'h0000000080000000, 0, 0, 0);
    applyStimulus(1, 0, 3'b100, 64'h1003, 64'd0, 64'h0000000080000000, 0, 0, 0);
    applyStimulus(0, 1, 3'b001, 64'h2006, 64'hABCD, 64'd0, 0, 0, 0);
    applyStimulus(1, 0, 3'b011, 64'h1008, 64'd0, 64'hCAFEF00DDEADBEEF, 4, 1, 1);
    applyStimulus(1, 0, 3'b010, 64'h1002, 64'd0, 64'h1122334455667788, 0, 0, 0);
    applyStimulus(1, 1, 3'b010, 64'h4004, 64'h0123456789ABCDEF, 64'd0, 1, 2, 0);
    applyStimulus(0, 1, 3'b101, 64'h5002, 64'hFFFF1234, 64'd0, 0, 0, 0);
    applyStimulus(1, 0, 3'b001, 64'h6000, 64'd0, 64'h00000000_0000ABCD, 0, 0, 0);

    // Start without a direction bit is dropped; a stray response in IDLE leaves rdata alone.
    @(negedge clk);
    start = 1'b1; memR = 1'b0; memW = 1'b0; addr = 64'h7000;
    #1 checkOutput("nodir_stall", {63'd0, stall}, 64'd0);
    @(negedge clk);
    start = 1'b0; bus.resp_valid = 1'b1; bus.resp_data = 64'h5555AAAA5555AAAA;
    #1 checkOutput("nodir_noreq", {63'd0, bus.req_valid}, 64'd0);
    @(negedge clk);
    bus.resp_valid = 1'b0;
    #1;
    checkOutput("idle_resp_done", {63'd0, done}, 64'd0);
    checkOutput("idle_resp_rdata", rdata, lastRdata);

    for (int i = 0; i < 16; i++) begin
      rnd = 1'($urandom);
      f3  = rnd ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 6));
      a   = {$urandom, $urandom};
      applyStimulus(!rnd, rnd, f3, a, {$urandom, $urandom}, {$urandom, $urandom},
                    $urandom_range(0, 3), $urandom_range(0, 3), 0);
    end

    // Reset lands while the access is waiting for its response.
    @(negedge clk);
    start = 1'b1; memR = 1'b1; memW = 1'b0; funct3 = 3'b011; addr = 64'h3000;
    @(negedge clk);
    start = 1'b0; memR = 1'b0; bus.req_ready = 1'b1;
    @(negedge clk);
    bus.req_ready = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    lastRdata = 64'd0;
    #1;
    checkOutput("midrst_stall", {63'd0, stall}, 64'd0);
    checkOutput("midrst_req_valid", {63'd0, bus.req_valid}, 64'd0);
    checkOutput("midrst_rdata", rdata, 64'd0);
    bus.resp_valid = 1'b1; bus.resp_data = 64'hFEEDFACE12345678;
    @(negedge clk);
    bus.resp_valid = 1'b0;
    #1;
    checkOutput("midrst_resp_done", {63'd0, done}, 64'd0);
    @(negedge clk);
    #1;
    checkOutput("midrst_resp_done2", {63'd0, done}, 64'd0);
    checkOutput("midrst_resp_rdata", rdata, 64'd0);

    applyStimulus(1, 0, 3'b110, 64'h8004, 64'd0, 64'h8765432100000000, 0, 0, 0);

    repeat (2) @(negedge clk);
    checkOutput("sb_empty", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
